counter_day: RTL and testbench
==============================

Name: counter_day

Overview:
- Day-of-month counter; the stage directly upstream of the month counter.
- Advances one day per enabled day_clk edge and wraps at the true month length, including the Gregorian leap-year rule.
- On each wrap it emits month_clk, which drives the month counter's month_clk input.
- Takes the current month and year back from the downstream month/year counters, and supports a user load of the day value.

Parameters:
- YEAR_W, 14, width of the year input (covers years 0..9999).
- DAY_W, 7, width of day value ports; matches the 7-bit field width used across the clock counters.

Ports:
- day_clk  input  1  sole clock; one rising edge per day tick.
- rst  input  1  synchronous, active-high reset, sampled on day_clk.
- en  input  1  count enable; low = hold.
- load  input  1  single-cycle request to load set_numb_day.
- set_numb_day  input  DAY_W  day value to load; range 1..31.
- month_w  input  7  current month from the month counter; 1..12 valid.
- year_w  input  YEAR_W  current year; used for leap decision.
- month_clk  output  1  registered one-cycle wrap pulse to the month counter.
- day_w  output  DAY_W  current day of month, 1-based.

Behaviour:
- All state updates on the rising edge of day_clk. Priority is rst > load > en-count > hold.
- Reset (rst=1 at an edge):
  - day_w <= 1, month_clk <= 0.
  - Overrides load and en in the same cycle, including reset mid-load.
- Month length (combinational, from month_w and year_w):
  - 1,3,5,7,8,10,12 -> 31.
  - 4,6,9,11 -> 30.
  - 2 -> 29 if leap, else 28.
  - month_w = 0 or > 12 -> 31 (tolerates the month counter's 0 reset value).
- Leap rule: (year mod 4 == 0 and year mod 100 != 0) or year mod 400 == 0.
- Count (en=1, load=0, rst=0):
  - If day_w >= last, then day_w <= 1 and month_clk <= 1.
  - Otherwise day_w <= day_w + 1 and month_clk <= 0.
  - The >= comparison (not ==) makes a stale day above the month length, e.g. day 31 after month changes to 4, wrap on the next tick instead of running away.
- Hold (en=0, load=0): day_w unchanged, month_clk <= 0. en low never clears the day value.
- Load (load=1, rst=0), regardless of en:
  - set_numb_day = 0 -> day_w <= 1.
  - set_numb_day > last -> day_w <= last (clamp).
  - Otherwise day_w <= set_numb_day.
  - month_clk <= 0; a load never generates a month pulse.
- month_clk timing:
  - High for exactly one day_clk cycle, in the cycle after the wrap edge; low on every other cycle.
  - Latency is one edge from the last-day tick to the pulse.
- month_w and year_w are sampled at the same edge as the count or load decision. The block does not re-clamp day_w when month_w or year_w change between edges.
- Width rules:
  - Arithmetic on DAY_W bits with no overflow possible, since max day is 31.
  - Year modulus is computed on the full YEAR_W bits.
- No state machine beyond the day register and the month_clk flop. Two outputs, both registered.

Decomposition:
- Shared package clock_pkg:
  - Month constants: MONTH_JAN..MONTH_DEC, DAYS_31 = 31, DAYS_30 = 30, DAYS_FEB = 28, DAYS_FEB_LEAP = 29.
  - Width constants: DAY_W, YEAR_W.
  - Function is_leap(year).
- One combinational sub-module, days_in_month: inputs month and year, output last day. It is also reused by the date-setting UI for range checking.
- counter_day holds only the day register, the priority logic and the month_clk flop.

Test Plan:
- Reset: assert rst for 2 edges with en=1, load=1, set_numb_day=15 -> day_w=1, month_clk=0; after release with en=1, the next edge gives day_w=2.
- 31-day wrap: month_w=1, load 30, then 2 enabled edges -> day_w 31 then 1; month_clk=1 only in the cycle after the wrap, 0 on the following edge.
- Leap February:
  - year_w=2024, month_w=2, load 28 -> ticks give 29 then 1 with a pulse.
  - year_w=1900 -> 28 wraps to 1.
  - year_w=2000 -> 29 is reached.
- Load clamp: month_w=4, set_numb_day=31, load -> day_w=30. set_numb_day=0 -> day_w=1. No month_clk pulse in either case.
- Enable and stale day:
  - en=0 for 5 edges at day 17 -> day_w stays 17, month_clk=0.
  - day_w=31 with month_w changed to 6 and en=1 -> the next edge gives day_w=1 and a month_clk pulse.
- Priority: at one edge drive rst=1, load=1, en=1 -> day_w=1. At the next edge drive load=1 (set 10) with en=1 -> day_w=10, not 2.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants and helpers for the calendar clock counters.
//   Month numbering : MONTH_JAN (1) .. MONTH_DEC (12)
//   Month lengths   : DAYS_31, DAYS_30, DAYS_FEB, DAYS_FEB_LEAP
//   Widths          : DAY_W (day value fields), YEAR_W (years 0..9999)
//   is_leap(year)   : Gregorian leap-year test
package clock_pkg;

    localparam int DAY_W  = 7;
    localparam int YEAR_W = 14;

    localparam logic [6:0] MONTH_JAN = 7'd1;
    localparam logic [6:0] MONTH_FEB = 7'd2;
    localparam logic [6:0] MONTH_MAR = 7'd3;
    localparam logic [6:0] MONTH_APR = 7'd4;
    localparam logic [6:0] MONTH_MAY = 7'd5;
    localparam logic [6:0] MONTH_JUN = 7'd6;
    localparam logic [6:0] MONTH_JUL = 7'd7;
    localparam logic [6:0] MONTH_AUG = 7'd8;
    localparam logic [6:0] MONTH_SEP = 7'd9;
    localparam logic [6:0] MONTH_OCT = 7'd10;
    localparam logic [6:0] MONTH_NOV = 7'd11;
    localparam logic [6:0] MONTH_DEC = 7'd12;

    localparam int DAYS_31       = 31;
    localparam int DAYS_30       = 30;
    localparam int DAYS_FEB      = 28;
    localparam int DAYS_FEB_LEAP = 29;

    // Year is passed zero-extended to 32 bits so callers of any year width
    // can share the function; the result equals the modulus on the native width.
    function automatic logic is_leap(input logic [31:0] year);
        return ((year % 32'd4 == 32'd0) && (year % 32'd100 != 32'd0)) ||
               (year % 32'd400 == 32'd0);
    endfunction

endpackage

// File: rtl/days_in_month.sv
// Combinational month-length lookup (also used by the date-setting UI).
//   month_i : month 1..12; 0 or >12 is treated as a 31-day month
//   year_i  : year, used for the February leap decision
//   last_o  : number of days in the month
module days_in_month
    import clock_pkg::*;
#(
    parameter int YR_W = clock_pkg::YEAR_W,
    parameter int DY_W = clock_pkg::DAY_W
) (
    input  logic [6:0]      month_i,
    input  logic [YR_W-1:0] year_i,
    output logic [DY_W-1:0] last_o
);

    logic leap;

    assign leap = is_leap(32'(year_i));

    always_comb begin
        last_o = DY_W'(DAYS_31);
        case (month_i)
            MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV: last_o = DY_W'(DAYS_30);
            MONTH_FEB: last_o = leap ? DY_W'(DAYS_FEB_LEAP) : DY_W'(DAYS_FEB);
            default:   last_o = DY_W'(DAYS_31);
        endcase
    end

endmodule

// File: rtl/counter_day.sv
// Day-of-month counter feeding the month counter.
//   day_clk      : clock, one rising edge per day tick
//   rst          : synchronous active-high reset
//   en           : count enable (low = hold)
//   load         : load set_numb_day (clamped to the month length)
//   set_numb_day : day value to load
//   month_w      : current month from the month counter
//   year_w       : current year, for the leap decision
//   month_clk    : registered one-cycle pulse after each wrap
//   day_w        : current day of month, 1-based
module counter_day #(
    parameter int YEAR_W = clock_pkg::YEAR_W,
    parameter int DAY_W  = clock_pkg::DAY_W
) (
    input  logic              day_clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [DAY_W-1:0]  set_numb_day,
    input  logic [6:0]        month_w,
    input  logic [YEAR_W-1:0] year_w,
    output logic              month_clk,
    output logic [DAY_W-1:0]  day_w
);

    localparam logic [DAY_W-1:0] DAY_ONE = DAY_W'(1);

    logic [DAY_W-1:0] last;
    logic [DAY_W-1:0] day_q, day_d;
    logic             mclk_q, mclk_d;

    days_in_month #(
        .YR_W (YEAR_W),
        .DY_W (DAY_W)
    ) u_days_in_month (
        .month_i (month_w),
        .year_i  (year_w),
        .last_o  (last)
    );

    always_comb begin
        day_d  = day_q;
        mclk_d = 1'b0;
        if (load) begin
            if (set_numb_day == '0)
                day_d = DAY_ONE;
            else if (set_numb_day > last)
                day_d = last;
            else
                day_d = set_numb_day;
        end else if (en) begin
            // >= so a stale day left above a shorter month wraps next tick
            if (day_q >= last) begin
                day_d  = DAY_ONE;
                mclk_d = 1'b1;
            end else begin
                day_d = day_q + DAY_ONE;
            end
        end
    end

    always_ff @(posedge day_clk) begin
        if (rst) begin
            day_q  <= DAY_ONE;
            mclk_q <= 1'b0;
        end else begin
            day_q  <= day_d;
            mclk_q <= mclk_d;
        end
    end

    assign day_w     = day_q;
    assign month_clk = mclk_q;

endmodule

// File: tb/tb_counter_day.sv
// Directed self-checking bench for counter_day.
module tb_counter_day;

    logic        day_clk = 1'b0;
    logic        rst, en, load;
    logic [6:0]  set_numb_day;
    logic [6:0]  month_w;
    logic [13:0] year_w;
    logic        month_clk;
    logic [6:0]  day_w;

    int vectors = 0;
    int fails   = 0;

    counter_day dut (
        .day_clk      (day_clk),
        .rst          (rst),
        .en           (en),
        .load         (load),
        .set_numb_day (set_numb_day),
        .month_w      (month_w),
        .year_w       (year_w),
        .month_clk    (month_clk),
        .day_w        (day_w)
    );

    always #5 day_clk = ~day_clk;

    task automatic tick();
        @(posedge day_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] dexp, input logic mexp);
        vectors++;
        assert (day_w === dexp && month_clk === mexp)
        else begin
            fails++;
            $error("FAIL %s: day_w=%0d month_clk=%0b, expected day_w=%0d month_clk=%0b",
                   tag, day_w, month_clk, dexp, mexp);
        end
    endtask

    task automatic do_load(input logic [6:0] v);
        load = 1'b1; set_numb_day = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b1; set_numb_day = 7'd15;
        month_w = 7'd1; year_w = 14'd2024;

        // reset overrides load/en
        tick(); chk("rst_edge1", 7'd1, 1'b0);
        tick(); chk("rst_edge2", 7'd1, 1'b0);
        rst = 1'b0; load = 1'b0;
        tick(); chk("post_rst_count", 7'd2, 1'b0);

        // 31-day wrap
        month_w = 7'd1;
        do_load(7'd30); chk("jan_load30", 7'd30, 1'b0);
        tick(); chk("jan_31", 7'd31, 1'b0);
        tick(); chk("jan_wrap", 7'd1, 1'b1);
        tick(); chk("jan_pulse_end", 7'd2, 1'b0);

        // leap February
        month_w = 7'd2; year_w = 14'd2024;
        do_load(7'd28); chk("feb2024_load", 7'd28, 1'b0);
        tick(); chk("feb2024_29", 7'd29, 1'b0);
        tick(); chk("feb2024_wrap", 7'd1, 1'b1);
        year_w = 14'd1900;
        do_load(7'd28); chk("feb1900_load", 7'd28, 1'b0);
        tick(); chk("feb1900_wrap", 7'd1, 1'b1);
        year_w = 14'd2000;
        do_load(7'd28); chk("feb2000_load", 7'd28, 1'b0);
        tick(); chk("feb2000_29", 7'd29, 1'b0);
        tick(); chk("feb2000_wrap", 7'd1, 1'b1);
        year_w = 14'd2023;
        do_load(7'd29); chk("feb2023_clamp", 7'd28, 1'b0);

        // load clamp and zero
        month_w = 7'd4;
        do_load(7'd31); chk("apr_clamp31", 7'd30, 1'b0);
        do_load(7'd0);  chk("apr_load0", 7'd1, 1'b0);

        // hold with en low (load still works with en low)
        en = 1'b0;
        do_load(7'd17); chk("hold_load17", 7'd17, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(); chk("hold", 7'd17, 1'b0);
        end

        // stale day above new month length
        month_w = 7'd1;
        do_load(7'd31); chk("stale_load31", 7'd31, 1'b0);
        month_w = 7'd6; en = 1'b1;
        tick(); chk("stale_wrap", 7'd1, 1'b1);

        // priority: rst > load > en
        rst = 1'b1; load = 1'b1; set_numb_day = 7'd10;
        tick(); chk("prio_rst", 7'd1, 1'b0);
        rst = 1'b0;
        tick(); chk("prio_load", 7'd10, 1'b0);
        load = 1'b0;
        tick(); chk("prio_count", 7'd11, 1'b0);

        // out-of-range month treated as 31 days
        month_w = 7'd0;
        do_load(7'd31); chk("month0_load31", 7'd31, 1'b0);
        month_w = 7'd13;
        tick(); chk("month13_wrap", 7'd1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
